// File: rtl/program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// program_memory_arbiter
//
// Shares the single combinational read port of the program-memory ROM between
// instruction fetch (requester 0) and the debug/loader read port (requester 1).
// The grant is combinational in the request cycle. The ROM word is registered
// at the end of that cycle and returned the next cycle with a one-cycle valid
// pulse on the winning port.
//
// Arbitration:
//   FETCH_PRIORITY = 0 : round-robin. On contention the requester that did not
//                        win last time is granted.
//   FETCH_PRIORITY = 1 : fetch wins contention. After MAX_STARVE consecutive
//                        fetch grants with debug pending, debug is forced in.
//
// Optional feature (macro PROGRAM_MEMORY_ADDR_CHECK_EN):
//   A granted address that is not word aligned, or whose word index
//   addr[16:2] is >= MEMORY_DEPTH, still returns rvalid. It also raises err
//   in the same cycle and returns 0 as rdata. With the macro undefined, the
//   err outputs are tied to 0 and no check logic is built.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   ifetch_req_i/addr_i        fetch request and byte address
//   ifetch_gnt_o               combinational grant to fetch
//   ifetch_rvalid_o/rdata_o    registered fetch read-data pulse and word
//   ifetch_err_o               fetch address error, qualified by rvalid
//   dbg_*                      same set for the debug/loader port
//   mem_addr_o                 byte address to the ROM (0 when nothing is granted)
//   mem_instr_i                instruction word from the ROM
// ---------------------------------------------------------------------------
module program_memory_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEMORY_DEPTH   = 32,
  parameter int unsigned FETCH_PRIORITY = 0,
  parameter int unsigned MAX_STARVE     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifetch_req_i,
  input  logic [DATA_WIDTH-1:0] ifetch_addr_i,
  output logic                  ifetch_gnt_o,
  output logic                  ifetch_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifetch_rdata_o,
  output logic                  ifetch_err_o,
  input  logic                  dbg_req_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_err_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_instr_i
);

  // The word index is taken from addr[16:2]. The starvation counter is 4 bits wide.
  if (DATA_WIDTH < 17 || MEMORY_DEPTH < 1 || MAX_STARVE < 1 || MAX_STARVE > 15)
  begin : g_param_check
    $error("program_memory_arbiter: illegal parameter combination");
  end

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DBG   = 1'b1
  } grant_e;

  grant_e                r_last_grant;
  logic [3:0]            r_starve_cnt;
  logic                  r_ifetch_rvalid;
  logic                  r_dbg_rvalid;
  logic [DATA_WIDTH-1:0] r_ifetch_rdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;

  logic                  w_ifetch_gnt;
  logic                  w_dbg_gnt;
  logic                  w_dbg_wins;
  logic [DATA_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_capture_data;

  // Contention winner. Fetch-priority mode yields only when the starvation
  // budget is spent. Round-robin hands the port to whoever did not win last.
  assign w_dbg_wins = (FETCH_PRIORITY != 0) ? (r_starve_cnt >= 4'(MAX_STARVE))
                                            : (r_last_grant == GRANT_FETCH);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_ifetch_gnt = 1'b0;
    w_dbg_gnt    = 1'b0;
    if (!reset) begin
      if (ifetch_req_i && dbg_req_i) begin
        w_dbg_gnt    = w_dbg_wins;
        w_ifetch_gnt = !w_dbg_wins;
      end else begin
        w_ifetch_gnt = ifetch_req_i;
        w_dbg_gnt    = dbg_req_i;
      end
    end
  end

  always_comb begin
    w_mem_addr = '0;
    if (w_ifetch_gnt) begin
      w_mem_addr = ifetch_addr_i;
    end else if (w_dbg_gnt) begin
      w_mem_addr = dbg_addr_i;
    end
  end

`ifdef PROGRAM_MEMORY_ADDR_CHECK_EN
  logic [14:0] w_word_idx;
  logic        w_addr_err;
  logic        r_ifetch_err;
  logic        r_dbg_err;

  assign w_word_idx     = w_mem_addr[16:2];
  assign w_addr_err     = (w_mem_addr[1:0] != 2'b00) ||
                          (32'(w_word_idx) >= 32'(MEMORY_DEPTH));
  assign w_capture_data = w_addr_err ? '0 : mem_instr_i;

  // Each err flag travels with its own rvalid and is cleared on every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifetch_err <= 1'b0;
      r_dbg_err    <= 1'b0;
    end else begin
      r_ifetch_err <= w_ifetch_gnt && w_addr_err;
      r_dbg_err    <= w_dbg_gnt && w_addr_err;
    end
  end

  assign ifetch_err_o = r_ifetch_err && !reset;
  assign dbg_err_o    = r_dbg_err && !reset;
`else
  assign w_capture_data = mem_instr_i;
  assign ifetch_err_o   = 1'b0;
  assign dbg_err_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_last_grant    <= GRANT_DBG;  // fetch wins the first contention
      r_starve_cnt    <= 4'd0;
      r_ifetch_rvalid <= 1'b0;
      r_dbg_rvalid    <= 1'b0;
      r_ifetch_rdata  <= '0;
      r_dbg_rdata     <= '0;
    end else begin
      r_ifetch_rvalid <= w_ifetch_gnt;
      r_dbg_rvalid    <= w_dbg_gnt;

      // Only the granted port's data register moves. The other port keeps its last word.
      if (w_ifetch_gnt) begin
        r_ifetch_rdata <= w_capture_data;
        r_last_grant   <= GRANT_FETCH;
      end
      if (w_dbg_gnt) begin
        r_dbg_rdata    <= w_capture_data;
        r_last_grant   <= GRANT_DBG;
      end

      // Counts fetch grants taken while debug waits. The count clears as soon
      // as debug is served or stops asking.
      if (!dbg_req_i || w_dbg_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (w_ifetch_gnt) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // While reset is high, every output reads 0, including a valid pulse that
  // was already registered in the cycle before reset.
  assign ifetch_gnt_o    = w_ifetch_gnt;
  assign dbg_gnt_o       = w_dbg_gnt;
  assign mem_addr_o      = w_mem_addr;
  assign ifetch_rvalid_o = r_ifetch_rvalid && !reset;
  assign dbg_rvalid_o    = r_dbg_rvalid && !reset;
  assign ifetch_rdata_o  = reset ? '0 : r_ifetch_rdata;
  assign dbg_rdata_o     = reset ? '0 : r_dbg_rdata;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for program_memory_arbiter. It builds one round-robin instance and one
// fetch-priority instance (MAX_STARVE = 4). Both instances share the request
// inputs, and each one has its own behavioural ROM.
// A table of directed cycles walks the documented scenarios. A randomized run
// then compares both instances against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_program_memory_arbiter;

  localparam int unsigned DW         = 32;
  localparam int unsigned DEPTH      = 32;
  localparam int          MAX_STARVE = 4;
`ifdef PROGRAM_MEMORY_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          f_req;
  logic [DW-1:0] f_addr;
  logic          d_req;
  logic [DW-1:0] d_addr;

  logic          rr_f_gnt, rr_f_rv, rr_f_err, rr_d_gnt, rr_d_rv, rr_d_err;
  logic [DW-1:0] rr_f_rdata, rr_d_rdata, rr_mem_addr, rr_instr;
  logic          fp_f_gnt, fp_f_rv, fp_f_err, fp_d_gnt, fp_d_rv, fp_d_err;
  logic [DW-1:0] fp_f_rdata, fp_d_rdata, fp_mem_addr, fp_instr;

  // ROM contents: word 2 holds 0x20080005, and every other index i holds 0xC0DE0000 | i.
  // Out-of-range indices return nonzero, so a missing forced zero is visible.
  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    logic [31:0] idx;
    idx = (byte_addr >> 2) & 32'h0000_7FFF;
    if (idx == 32'd2) return 32'h2008_0005;
    return 32'hC0DE_0000 | idx;
  endfunction

  assign rr_instr = rom_word(rr_mem_addr);
  assign fp_instr = rom_word(fp_mem_addr);

  program_memory_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH),
                           .FETCH_PRIORITY(0), .MAX_STARVE(MAX_STARVE)) u_rr (
    .clk(clk), .reset(rst),
    .ifetch_req_i(f_req), .ifetch_addr_i(f_addr), .ifetch_gnt_o(rr_f_gnt),
    .ifetch_rvalid_o(rr_f_rv), .ifetch_rdata_o(rr_f_rdata), .ifetch_err_o(rr_f_err),
    .dbg_req_i(d_req), .dbg_addr_i(d_addr), .dbg_gnt_o(rr_d_gnt),
    .dbg_rvalid_o(rr_d_rv), .dbg_rdata_o(rr_d_rdata), .dbg_err_o(rr_d_err),
    .mem_addr_o(rr_mem_addr), .mem_instr_i(rr_instr)
  );

  program_memory_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH),
                           .FETCH_PRIORITY(1), .MAX_STARVE(MAX_STARVE)) u_fp (
    .clk(clk), .reset(rst),
    .ifetch_req_i(f_req), .ifetch_addr_i(f_addr), .ifetch_gnt_o(fp_f_gnt),
    .ifetch_rvalid_o(fp_f_rv), .ifetch_rdata_o(fp_f_rdata), .ifetch_err_o(fp_f_err),
    .dbg_req_i(d_req), .dbg_addr_i(d_addr), .dbg_gnt_o(fp_d_gnt),
    .dbg_rvalid_o(fp_d_rv), .dbg_rdata_o(fp_d_rdata), .dbg_err_o(fp_d_err),
    .mem_addr_o(fp_mem_addr), .mem_instr_i(fp_instr)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ directed table
  typedef struct {
    bit          rst;
    bit          rf;
    logic [31:0] af;
    bit          rd;
    logic [31:0] ad;
    bit          chk_rr;   // when 0, only the fetch-priority grant is checked
    bit   [1:0]  gnt;      // {fetch, dbg} for the round-robin instance
    logic [31:0] addr;
    bit   [1:0]  rv;
    logic [31:0] rdf;
    logic [31:0] rdd;
    bit   [1:0]  err;
    bit   [1:0]  fp_gnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit rst_v, input bit rf_v, input logic [31:0] af_v,
                         input bit rd_v, input logic [31:0] ad_v, input bit chk,
                         input bit [1:0] g, input logic [31:0] a, input bit [1:0] rv,
                         input logic [31:0] rdf, input logic [31:0] rdd,
                         input bit [1:0] er, input bit [1:0] fpg);
    vec_t v;
    v.rst = rst_v; v.rf = rf_v; v.af = af_v; v.rd = rd_v; v.ad = ad_v;
    v.chk_rr = chk; v.gnt = g; v.addr = a; v.rv = rv; v.rdf = rdf; v.rdd = rdd;
    v.err = er; v.fp_gnt = fpg;
    vecs.push_back(v);
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct {
    int          last;     // 0 = fetch won last, 1 = dbg won last
    int          streak;   // fetch grants in a row while dbg waited
    bit          rv_f, rv_d;
    logic [31:0] rd_f, rd_d;
    bit          er_f, er_d;
  } model_t;

  model_t m_rr, m_fp;

  function automatic model_t model_reset();
    model_t m;
    m.last = 1; m.streak = 0;
    m.rv_f = 1'b0; m.rv_d = 1'b0; m.rd_f = '0; m.rd_d = '0;
    m.er_f = 1'b0; m.er_d = 1'b0;
    return m;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    if (!ADDR_CHK) return 1'b0;
    return (a % 4 != 0) || (((a >> 2) & 32'h7FFF) >= DEPTH);
  endfunction

  // Returns the winner for this cycle: -1 = nobody, 0 = fetch, 1 = dbg.
  function automatic int pick(input model_t m, input bit fp);
    if (rst || (!f_req && !d_req)) return -1;
    if (f_req && !d_req) return 0;
    if (d_req && !f_req) return 1;
    if (fp) return (m.streak >= MAX_STARVE) ? 1 : 0;
    return (m.last == 0) ? 1 : 0;
  endfunction

  function automatic model_t advance(input model_t m, input bit fp);
    model_t n;
    int     g;
    if (rst) return model_reset();
    g = pick(m, fp);
    n = m;
    n.rv_f = (g == 0); n.rv_d = (g == 1);
    n.er_f = 1'b0;     n.er_d = 1'b0;
    if (g == 0) begin
      n.er_f = addr_bad(f_addr);
      n.rd_f = n.er_f ? 32'h0 : rom_word(f_addr);
      n.last = 0;
    end
    if (g == 1) begin
      n.er_d = addr_bad(d_addr);
      n.rd_d = n.er_d ? 32'h0 : rom_word(d_addr);
      n.last = 1;
    end
    if (!d_req || g == 1) n.streak = 0;
    else if (g == 0)      n.streak = n.streak + 1;
    return n;
  endfunction

  task automatic check_outputs(input string tag, input model_t m, input bit fp,
                               input logic gf, input logic gd, input logic [31:0] ma,
                               input logic vf, input logic vd,
                               input logic [31:0] rdf, input logic [31:0] rdd,
                               input logic ef, input logic ed);
    int          g;
    logic [31:0] ea;
    g  = pick(m, fp);
    ea = (g == 0) ? f_addr : (g == 1) ? d_addr : 32'h0;
    check({tag, ".gnt"},      {30'd0, gf, gd}, {30'd0, g == 0, g == 1});
    check({tag, ".mem_addr"}, ma, ea);
    if (rst) begin
      check({tag, ".rvalid"},  {30'd0, vf, vd}, 32'h0);
      check({tag, ".rdata_f"}, rdf, 32'h0);
      check({tag, ".rdata_d"}, rdd, 32'h0);
      check({tag, ".err"},     {30'd0, ef, ed}, 32'h0);
    end else begin
      check({tag, ".rvalid"},  {30'd0, vf, vd}, {30'd0, m.rv_f, m.rv_d});
      check({tag, ".rdata_f"}, rdf, m.rd_f);
      check({tag, ".rdata_d"}, rdd, m.rd_d);
      check({tag, ".err"},     {30'd0, ef, ed}, {30'd0, m.er_f, m.er_d});
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
    case ($urandom_range(0, 3))
      0: ;
      1: a = a | 32'($urandom_range(1, 3));
      2: a = 32'($urandom_range(32, 32767)) << 2;
      default: a = ($urandom & 32'hFFFE_0000) | a;
    endcase
    return a;
  endfunction

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [31:0] w0, w1, w3, w4, w5, w20, w1f, r2, e_rd;
    bit   [1:0]  e_er;
    rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_addr = '0;

    r2  = 32'h2008_0005;
    w0  = 32'hC0DE_0000; w1 = 32'hC0DE_0001; w3 = 32'hC0DE_0003;
    w4  = 32'hC0DE_0004; w5 = 32'hC0DE_0005; w20 = 32'hC0DE_0020; w1f = 32'hC0DE_001F;
    e_rd = ADDR_CHK ? 32'h0 : w20;
    e_er = ADDR_CHK ? 2'b01 : 2'b00;

    //       rst rf af            rd ad     chk gnt   addr          rv    rdf  rdd   err   fpg
    // Reset while both request, then a single fetch of 0x00400008.
    add_vec(1, 1, 32'h0,        1, 32'h0,  1, 2'b00, 32'h0,        2'b00, 0,   0,    2'b00, 2'b00);
    add_vec(0, 1, 32'h00400008, 0, 32'h0,  1, 2'b10, 32'h00400008, 2'b00, 0,   0,    2'b00, 2'b10);
    add_vec(0, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b10, r2,  0,    2'b00, 2'b00);
    // Round-robin contention from reset goes F,D,F,D.
    add_vec(1, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b00, 0,   0,    2'b00, 2'b00);
    add_vec(0, 1, 32'h4,        1, 32'h8,  1, 2'b10, 32'h4,        2'b00, 0,   0,    2'b00, 2'b10);
    add_vec(0, 1, 32'hC,        1, 32'h8,  1, 2'b01, 32'h8,        2'b10, w1,  0,    2'b00, 2'b10);
    add_vec(0, 1, 32'hC,        1, 32'h10, 1, 2'b10, 32'hC,        2'b01, w1,  r2,   2'b00, 2'b10);
    add_vec(0, 1, 32'h10,       1, 32'h10, 1, 2'b01, 32'h10,       2'b10, w3,  r2,   2'b00, 2'b10);
    add_vec(0, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b01, w3,  w4,   2'b00, 2'b00);
    // Fetch-priority starvation guard: F,F,F,F,D repeated.
    for (int i = 0; i < 10; i++)
      add_vec(0, 1, 32'h0, 1, 32'h4, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00,
              (i == 4 || i == 9) ? 2'b01 : 2'b10);
    // Two fetch grants, dbg drops for a cycle (count clears), then a full F,F,F,F,D run.
    add_vec(0, 1, 32'h0, 1, 32'h4, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b10);
    add_vec(0, 1, 32'h0, 1, 32'h4, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b10);
    add_vec(0, 1, 32'h0, 0, 32'h4, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b10);
    for (int i = 0; i < 5; i++)
      add_vec(0, 1, 32'h0, 1, 32'h4, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00,
              (i == 4) ? 2'b01 : 2'b10);
    // One dbg read, then back-to-back fetches of 0x0, 0x4, 0x8. dbg_rdata must hold.
    add_vec(1, 1, 32'h0,        1, 32'h0,  1, 2'b00, 32'h0,        2'b00, 0,   0,    2'b00, 2'b00);
    add_vec(0, 0, 32'h0,        1, 32'hC,  1, 2'b01, 32'hC,        2'b00, 0,   0,    2'b00, 2'b01);
    add_vec(0, 1, 32'h0,        0, 32'h0,  1, 2'b10, 32'h0,        2'b01, 0,   w3,   2'b00, 2'b10);
    add_vec(0, 1, 32'h4,        0, 32'h0,  1, 2'b10, 32'h4,        2'b10, w0,  w3,   2'b00, 2'b10);
    add_vec(0, 1, 32'h8,        0, 32'h0,  1, 2'b10, 32'h8,        2'b10, w1,  w3,   2'b00, 2'b10);
    add_vec(0, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b10, r2,  w3,   2'b00, 2'b00);
    // Reset in the cycle after a grant. The pending rvalid is dropped, and fetch wins the next contention.
    add_vec(0, 1, 32'h10,       0, 32'h0,  1, 2'b10, 32'h10,       2'b00, r2,  w3,   2'b00, 2'b10);
    add_vec(1, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b00, 0,   0,    2'b00, 2'b00);
    add_vec(0, 1, 32'h14,       1, 32'h18, 1, 2'b10, 32'h14,       2'b00, 0,   0,    2'b00, 2'b10);
    add_vec(0, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b10, w5,  0,    2'b00, 2'b00);
    // Address check: 0x82 is misaligned, 0x80 is index 32, and 0x7C is index 31.
    add_vec(0, 0, 32'h0,        1, 32'h82, 1, 2'b01, 32'h82,       2'b00, w5,  0,    2'b00, 2'b01);
    add_vec(0, 0, 32'h0,        1, 32'h80, 1, 2'b01, 32'h80,       2'b01, w5,  e_rd, e_er,  2'b01);
    add_vec(0, 0, 32'h0,        1, 32'h7C, 1, 2'b01, 32'h7C,       2'b01, w5,  e_rd, e_er,  2'b01);
    add_vec(0, 0, 32'h0,        0, 32'h0,  1, 2'b00, 32'h0,        2'b01, w5,  w1f,  2'b00, 2'b00);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; f_req = vecs[i].rf; f_addr = vecs[i].af;
      d_req = vecs[i].rd; d_addr = vecs[i].ad;
      #1;
      check($sformatf("row%0d.fp_gnt", i), {30'd0, fp_f_gnt, fp_d_gnt}, {30'd0, vecs[i].fp_gnt});
      if (vecs[i].chk_rr) begin
        check($sformatf("row%0d.gnt", i),     {30'd0, rr_f_gnt, rr_d_gnt}, {30'd0, vecs[i].gnt});
        check($sformatf("row%0d.mem_addr", i), rr_mem_addr, vecs[i].addr);
        check($sformatf("row%0d.rvalid", i),  {30'd0, rr_f_rv, rr_d_rv}, {30'd0, vecs[i].rv});
        check($sformatf("row%0d.rdata_f", i),  rr_f_rdata, vecs[i].rdf);
        check($sformatf("row%0d.rdata_d", i),  rr_d_rdata, vecs[i].rdd);
        check($sformatf("row%0d.err", i),     {30'd0, rr_f_err, rr_d_err}, {30'd0, vecs[i].err});
      end
    end

    // Randomized run against the reference model, starting with a reset cycle.
    m_rr = model_reset();
    m_fp = model_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst    = (c == 0) || ($urandom_range(0, 49) == 0);
      f_req  = ($urandom_range(0, 9) < 8);
      d_req  = ($urandom_range(0, 9) < 8);
      f_addr = rand_addr();
      d_addr = rand_addr();
      #1;
      check_outputs("rr", m_rr, 1'b0, rr_f_gnt, rr_d_gnt, rr_mem_addr, rr_f_rv, rr_d_rv,
                    rr_f_rdata, rr_d_rdata, rr_f_err, rr_d_err);
      check_outputs("fp", m_fp, 1'b1, fp_f_gnt, fp_d_gnt, fp_mem_addr, fp_f_rv, fp_d_rv,
                    fp_f_rdata, fp_d_rdata, fp_f_err, fp_d_err);
      @(posedge clk);
      m_rr = advance(m_rr, 1'b0);
      m_fp = advance(m_fp, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
